mul_arbiter: RTL and testbench

Round-robin controller that shares one multi-cycle multiplier (8x8 -> 16, start/done handshake, fixed 4-cycle latency) among N_REQ requesters. It accepts one request at a time, holds the operands on the multiplier, and pulses start. It then waits for done, or times out, and returns the product with the requester ID on a shared response channel that supports backpressure. It sits between the ALU-level requesters and the multiplier instance.

---
 rtl/mul_arbiter.sv | 122 ++++++++++++
 tb/tb_mul_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sharing of one start/done multiplier among N_REQ requesters
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int MUL_LAT = 4,
  parameter int TIMEOUT = 16,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*DW-1:0]     rsp_result,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  input  logic                mul_done,
  input  logic [2*DW-1:0]     mul_result,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   cnt;
  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  int              idx;
  logic [IDW-1:0]  idx_v;

  // Scan requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    sel_a       = '0;
    sel_b       = '0;
    idx         = 0;
    idx_v       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(rr_ptr) + k) % N_REQ;
      idx_v = idx[IDW-1:0];
      if (!grant_found && req_valid[idx_v]) begin
        grant_found = 1'b1;
        grant_id    = idx_v;
        sel_a       = req_a[idx*DW +: DW];
        sel_b       = req_b[idx*DW +: DW];
      end
    end
    req_ready = '0;
    if (state == IDLE && !rst && grant_found) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            mul_a     <= sel_a;
            mul_b     <= sel_b;
            rsp_id    <= grant_id;
            rr_ptr    <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A done arriving earlier than the multiplier latency is a leftover and is dropped.
          if (mul_done && cnt >= CW'(MUL_LAT - 1)) begin
            rsp_result <= mul_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - randomized bench for mul_arbiter against a transaction-level model
module tb_mul_arbiter;
  localparam int N = 4, DW = 8, LAT = 4, TO = 16;

  logic            clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic            rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_result, mul_result = '0;
  logic            mul_start, mul_done = 1'b0, busy;
  logic [7:0]      mul_a, mul_b;

  mul_arbiter #(.N_REQ(N), .DW(DW), .MUL_LAT(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [N-1:0] rv = '0;
  logic [7:0]   ra [N];
  logic [7:0]   rb [N];
  int rr_m = 0, acc_id = 0, t = 0, exp_a = 0, exp_b = 0, exp_id = 0, exp_lat = 0;
  bit in_flight = 0, start_due = 0, acc_pending = 0, mul_active = 0, exp_err = 0;
  bit [31:0] done_mask = '0;
  logic [15:0] exp_res = '0, last_res = '0;
  int last_id = 0, ops_done = 0;
  bit last_err = 0;
  int rsp_ids[$];
  logic [15:0] rsp_vals[$];
  logic [N-1:0] gen_mask = '0;
  int gen_prob = 0, rdy_prob = 100, mode_sel = 0, bp_cnt = 0;
  bit fix_ops = 0, bp_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Multiplier behaviour for one operation: done pulses at chosen offsets from start.
  task automatic build_schedule();
    int mode, first;
    mode = (mode_sel < 0) ? int'($urandom_range(7, 0)) : mode_sel;
    done_mask = '0;
    case (mode)
      0: done_mask[LAT] = 1'b1;
      1: done_mask[$urandom_range(TO, LAT)] = 1'b1;
      2: begin done_mask[$urandom_range(LAT-1, 1)] = 1'b1; done_mask[$urandom_range(TO, LAT)] = 1'b1; end
      3: ;
      4: done_mask[$urandom_range(LAT-1, 1)] = 1'b1;
      5: done_mask[TO] = 1'b1;
      6: done_mask[TO+1] = 1'b1;
      default: begin done_mask[2] = 1'b1; done_mask[4] = 1'b1; end
    endcase
    first = -1;
    for (int l = LAT; l <= TO; l++)
      if (first < 0 && done_mask[l]) first = l;
    if (first >= 0) begin
      exp_err = 0; exp_res = 16'(exp_a * exp_b); exp_lat = first + 1;
    end else begin
      exp_err = 1; exp_res = '0; exp_lat = TO + 1;
    end
  endtask

  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    bit exp_v;
    @(negedge clk);
    cyc++;
    if (acc_pending) rv[acc_id] = 1'b0;
    acc_pending = 0;
    for (int i = 0; i < N; i++)
      if (!rv[i] && gen_mask[i] && int'($urandom_range(99, 0)) < gen_prob) begin
        rv[i] = 1'b1;
        ra[i] = fix_ops ? 8'(i + 1) : 8'($urandom);
        rb[i] = fix_ops ? 8'd3 : 8'($urandom);
      end
    if (bp_mode) begin
      if (rsp_valid && bp_cnt < 3) begin rsp_ready = 1'b0; bp_cnt++; end
      else rsp_ready = 1'b1;
    end else rsp_ready = int'($urandom_range(99, 0)) < rdy_prob;
    if (mul_active) t++;
    mul_done   = mul_active && t < 32 && done_mask[t];
    mul_result = (mul_done && t >= LAT && t <= TO) ? exp_res : 16'($urandom);
    req_valid  = rv;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = ra[i];
      req_b[i*DW +: DW] = rb[i];
    end
    #1;
    w = winner(rv, rr_m);
    exp_rdy = '0;
    if (!in_flight && w >= 0) exp_rdy[w] = 1'b1;
    exp_v = in_flight && mul_active && t >= exp_lat;
    check("req_ready", req_ready, exp_rdy);
    check("mul_start", mul_start, start_due);
    check("busy", busy, in_flight);
    check("rsp_valid", rsp_valid, exp_v);
    if (exp_v && rsp_valid) begin
      check("rsp_id", rsp_id, exp_id);
      check("rsp_result", rsp_result, exp_res);
      check("rsp_err", rsp_err, exp_err);
    end
    if (start_due) begin
      check("mul_a", mul_a, exp_a);
      check("mul_b", mul_b, exp_b);
      t = 0; mul_active = 1; start_due = 0;
      build_schedule();
    end
    if (exp_v && rsp_ready) begin
      in_flight = 0; ops_done++; bp_cnt = 0;
      last_res = rsp_result; last_id = int'(rsp_id); last_err = rsp_err;
      rsp_ids.push_back(int'(rsp_id)); rsp_vals.push_back(rsp_result);
    end
    if (exp_rdy != '0) begin
      acc_pending = 1; acc_id = w; in_flight = 1; start_due = 1; mul_active = 0;
      rr_m = (w + 1) % N; exp_a = int'(ra[w]); exp_b = int'(rb[w]); exp_id = w;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (!(!in_flight && rv == '0 && !start_due && !acc_pending) && n < budget) begin
      cycle(); n++;
    end
    check("idle_reached", n < budget, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; mul_done = 1'b0; rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0; rv = '0; cyc++;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    check("rst_busy", busy, 0);
    rr_m = 0; in_flight = 0; start_due = 0; acc_pending = 0; mul_active = 0; bp_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
    do_reset();

    // Single operation, nominal latency.
    mode_sel = 0; rv[0] = 1'b1; ra[0] = 8'd12; rb[0] = 8'd10;
    run_until_idle(40);
    check("t1_result", last_res, 120);
    check("t1_id", last_id, 0);

    // Fairness with all requesters held high.
    do_reset();
    rsp_ids.delete(); rsp_vals.delete();
    fix_ops = 1; gen_mask = '1; gen_prob = 100;
    begin
      int n0 = ops_done, n = 0;
      while (ops_done - n0 < 5 && n < 100) begin cycle(); n++; end
    end
    gen_mask = '0;
    run_until_idle(100);
    fix_ops = 0;
    for (int k = 0; k < 5; k++) begin
      check("t2_id", rsp_ids[k], k % 4);
      check("t2_result", rsp_vals[k], 3 * ((k % 4) + 1));
    end

    // Timeout on requester 2, then a normal operation.
    mode_sel = 3; rv[2] = 1'b1; ra[2] = 8'd7; rb[2] = 8'd9;
    run_until_idle(40);
    check("t3_err", last_err, 1);
    check("t3_id", last_id, 2);
    check("t3_result", last_res, 0);
    mode_sel = 1; rv[1] = 1'b1; ra[1] = 8'd200; rb[1] = 8'd3;
    run_until_idle(40);
    check("t3_next_result", last_res, 600);
    check("t3_next_err", last_err, 0);

    // Backpressure for three cycles.
    bp_mode = 1; mode_sel = 0; rv[0] = 1'b1; ra[0] = 8'd5; rb[0] = 8'd6;
    run_until_idle(40);
    bp_mode = 0;
    check("t4_result", last_res, 30);

    // Pointer wrap from 3 to 0; done coinciding with the last timeout cycle.
    mode_sel = 0; rv[2] = 1'b1; ra[2] = 8'd1; rb[2] = 8'd1;
    run_until_idle(40);
    rsp_ids.delete(); rsp_vals.delete();
    mode_sel = 5; rv = 4'b1001; ra[0] = 8'd11; rb[0] = 8'd11; ra[3] = 8'd9; rb[3] = 8'd8;
    run_until_idle(80);
    check("t6_first", rsp_ids[0], 3);
    check("t6_second", rsp_ids[1], 0);
    check("t6_val3", rsp_vals[0], 72);
    check("t6_err", last_err, 0);

    // Reset in the middle of WAIT, then a stale done ahead of the real one.
    mode_sel = 0; rv[1] = 1'b1; ra[1] = 8'd4; rb[1] = 8'd4;
    begin
      int n = 0;
      while (!(mul_active && t == 3) && n < 20) begin cycle(); n++; end
      check("t5_reached_wait", n < 20, 1);
    end
    do_reset();
    mode_sel = 7; rv[0] = 1'b1; ra[0] = 8'd255; rb[0] = 8'd255;
    run_until_idle(40);
    check("t5_result", last_res, 65025);
    check("t5_err", last_err, 0);

    // Randomized traffic.
    do_reset();
    begin
      int n0 = ops_done;
      gen_mask = '1; gen_prob = 25; rdy_prob = 70; mode_sel = -1;
      repeat (2000) cycle();
      gen_mask = '0; rdy_prob = 100;
      run_until_idle(300);
      check("random_ops", (ops_done - n0) > 50, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
